// File: rtl/util_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | util_fifo_pkg : width constants shared by the step-up/step-down FIFOs |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package util_fifo_pkg;

  // Step-down FIFO (64 -> 32)
  localparam int DIN_W  = 64;
  localparam int DOUT_W = 32;

  // Step-up FIFO (32 -> 64)
  localparam int SU_DIN_W  = 32;
  localparam int SU_DOUT_W = 64;

  // Word-count output width used by both FIFOs
  localparam int CNT_W = 32;

  // Select one half of a wide word, low half when hi == 0.
  function automatic logic [DOUT_W-1:0] half_of(input logic [DIN_W-1:0] word,
                                                input logic              hi);
    return hi ? word[DIN_W-1:DOUT_W] : word[DOUT_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/util_stepdown_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | util_stepdown_fifo_if : handshake bundle for the 64->32 FIFO          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface util_stepdown_fifo_if;

  logic                               wren;
  logic                               rden;
  logic [util_fifo_pkg::DIN_W-1:0]    din;
  logic [util_fifo_pkg::DOUT_W-1:0]   dout;
  logic                               full;
  logic                               empty;
  logic [util_fifo_pkg::CNT_W-1:0]    dcnt;

  // master: producer/consumer side driving requests
  modport master (
    output wren, rden, din,
    input  dout, full, empty, dcnt
  );

  // slave: the FIFO itself
  modport slave (
    input  wren, rden, din,
    output dout, full, empty, dcnt
  );

endinterface
`default_nettype wire

// File: rtl/util_sdp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | util_sdp_ram : simple dual-port RAM, sync write / async read          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module util_sdp_ram #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             i_we,
  input  wire logic [AW-1:0]    i_waddr,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic [AW-1:0]    i_raddr,
  output logic      [WIDTH-1:0] o_rdata
);

  // No reset on storage so the array maps onto distributed RAM.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/util_stepdown_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | util_stepdown_fifo : 64-bit in, 32-bit out synchronous FIFO           |
// | Low half of each slot is delivered first. Rev 1.0                     |
// +----------------------------------------------------------------------+
module util_stepdown_fifo
  import util_fifo_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  util_stepdown_fifo_if.slave  bus
);

  localparam logic [AW:0] c_depth_slots = (AW+1)'(DEPTH);

  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic               r_half_sel;
  logic [DOUT_W-1:0]  r_dout;

  logic [AW:0]        w_slots;
  logic [CNT_W-1:0]   w_dcnt;
  logic               w_full;
  logic               w_empty;
  logic               w_wr_acc;
  logic               w_rd_acc;
  logic [DIN_W-1:0]   w_rd_word;

  // Flags come straight from the registered pointers, so they track an
  // asynchronous reset without waiting for a clock edge.
  assign w_slots  = r_wr_ptr - r_rd_ptr;
  assign w_dcnt   = (CNT_W'(w_slots) << 1) - CNT_W'(r_half_sel);
  assign w_full   = (w_slots == c_depth_slots);
  assign w_empty  = (w_dcnt == '0);

  assign w_wr_acc = bus.wren && !w_full;
  assign w_rd_acc = bus.rden && !w_empty;

  util_sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DIN_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (bus.din),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rd_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (w_wr_acc) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // A slot is released only after its high half has been delivered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= '0;
      r_half_sel <= 1'b0;
      r_dout     <= '0;
    end else if (w_rd_acc) begin
      r_dout <= half_of(w_rd_word, r_half_sel);
      if (r_half_sel) begin
        r_half_sel <= 1'b0;
        r_rd_ptr   <= r_rd_ptr + 1'b1;
      end else begin
        r_half_sel <= 1'b1;
      end
    end
  end

  assign bus.dout  = r_dout;
  assign bus.full  = w_full;
  assign bus.empty = w_empty;
  assign bus.dcnt  = w_dcnt;

endmodule
`default_nettype wire

// File: tb/tb_util_stepdown_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_util_stepdown_fifo : self-checking bench for util_stepdown_fifo    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_util_stepdown_fifo;
  import util_fifo_pkg::*;

  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  util_stepdown_fifo_if bus();

  util_stepdown_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: a plain queue of 32-bit words still to be delivered.
  logic [31:0] mq[$];
  logic [31:0] m_dout;

  typedef struct {
    logic        wren;
    logic        rden;
    logic [63:0] din;
    logic [31:0] dout;
    logic        full;
    logic        empty;
    logic [31:0] dcnt;
  } vec_t;

  vec_t vecs[7];

  function automatic int m_slots();
    return (mq.size() + 1) / 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".dout"},  bus.dout, m_dout);
    chk({tag, ".full"},  {31'b0, bus.full},  {31'b0, (m_slots() == DEPTH)});
    chk({tag, ".empty"}, {31'b0, bus.empty}, {31'b0, (mq.size() == 0)});
    chk({tag, ".dcnt"},  bus.dcnt, 32'(mq.size()));
  endtask

  // One clock: acceptance decided from pre-edge model state.
  task automatic cycle(input logic we, input logic re, input logic [63:0] d);
    bit wr_ok, rd_ok;
    bus.wren = we;
    bus.rden = re;
    bus.din  = d;
    wr_ok = we && (m_slots() < DEPTH);
    rd_ok = re && (mq.size() > 0);
    @(posedge clk);
    #1;
    if (rd_ok) m_dout = mq.pop_front();
    if (wr_ok) begin
      mq.push_back(d[31:0]);
      mq.push_back(d[63:32]);
    end
    bus.wren = 1'b0;
    bus.rden = 1'b0;
  endtask

  // Asserts reset between edges and checks outputs before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, ".rst_empty"}, {31'b0, bus.empty}, 32'd1);
    chk({tag, ".rst_full"},  {31'b0, bus.full},  32'd0);
    chk({tag, ".rst_dcnt"},  bus.dcnt, 32'd0);
    chk({tag, ".rst_dout"},  bus.dout, 32'd0);
    mq.delete();
    m_dout = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 2 * DEPTH + 2 && mq.size() > 0; n++) begin
      cycle(1'b0, 1'b1, 64'd0);
      check_model(tag);
    end
    chk({tag, ".drained"}, {31'b0, bus.empty}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] k;
    logic [31:0] next_exp;
    bit          we, re;

    bus.wren = 1'b0;
    bus.rden = 1'b0;
    bus.din  = '0;
    m_dout   = '0;

    do_reset("init");

    // Order check: low half first, dcnt 4,3,2,1,0.
    vecs[0] = '{1'b1, 1'b0, 64'h0000_0002_0000_0001, 32'd0, 1'b0, 1'b0, 32'd2};
    vecs[1] = '{1'b1, 1'b0, 64'h0000_0004_0000_0003, 32'd0, 1'b0, 1'b0, 32'd4};
    vecs[2] = '{1'b0, 1'b1, 64'd0,                   32'd1, 1'b0, 1'b0, 32'd3};
    vecs[3] = '{1'b0, 1'b1, 64'd0,                   32'd2, 1'b0, 1'b0, 32'd2};
    vecs[4] = '{1'b0, 1'b1, 64'd0,                   32'd3, 1'b0, 1'b0, 32'd1};
    vecs[5] = '{1'b0, 1'b1, 64'd0,                   32'd4, 1'b0, 1'b1, 32'd0};
    vecs[6] = '{1'b0, 1'b1, 64'd0,                   32'd4, 1'b0, 1'b1, 32'd0};
    for (int i = 0; i < 7; i++) begin
      cycle(vecs[i].wren, vecs[i].rden, vecs[i].din);
      chk($sformatf("vec%0d.dout", i),  bus.dout, vecs[i].dout);
      chk($sformatf("vec%0d.full", i),  {31'b0, bus.full},  {31'b0, vecs[i].full});
      chk($sformatf("vec%0d.empty", i), {31'b0, bus.empty}, {31'b0, vecs[i].empty});
      chk($sformatf("vec%0d.dcnt", i),  bus.dcnt, vecs[i].dcnt);
    end

    // Full boundary.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, {32'(100 + 2 * i + 1), 32'(100 + 2 * i)});
      check_model("fill");
    end
    chk("full_at_16", {31'b0, bus.full}, 32'd1);
    chk("dcnt_at_16", bus.dcnt, 32'd32);
    cycle(1'b1, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("w17_dcnt", bus.dcnt, 32'd32);
    check_model("w17");
    cycle(1'b0, 1'b1, 64'd0);
    chk("rd1_full", {31'b0, bus.full}, 32'd1);
    chk("rd1_dcnt", bus.dcnt, 32'd31);
    cycle(1'b0, 1'b1, 64'd0);
    chk("rd2_full", {31'b0, bus.full}, 32'd0);
    chk("rd2_dcnt", bus.dcnt, 32'd30);

    // Full with a half consumed: read frees a slot, same-cycle write rejected.
    cycle(1'b1, 1'b0, 64'h0000_0A01_0000_0A00);
    chk("refill_full", {31'b0, bus.full}, 32'd1);
    cycle(1'b0, 1'b1, 64'd0);
    chk("half_full", {31'b0, bus.full}, 32'd1);
    chk("half_dcnt", bus.dcnt, 32'd31);
    cycle(1'b1, 1'b1, 64'hBAD0_0001_BAD0_0000);
    chk("sim_full", {31'b0, bus.full}, 32'd0);
    chk("sim_dcnt", bus.dcnt, 32'd30);
    check_model("sim");
    cycle(1'b1, 1'b0, 64'h0000_0B01_0000_0B00);
    chk("after_full", {31'b0, bus.full}, 32'd1);
    chk("after_dcnt", bus.dcnt, 32'd32);
    drain("drain_full");

    // Empty boundary: reads on empty are ignored.
    held = bus.dout;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 64'd0);
      chk("empty_rd_dout", bus.dout, held);
      chk("empty_rd_dcnt", bus.dcnt, 32'd0);
    end
    cycle(1'b1, 1'b0, 64'h0000_0C01_0000_0C00);
    check_model("post_empty_wr");
    drain("post_empty");

    // Counter-driven streaming across pointer wrap.
    do_reset("stream");
    k = '0;
    next_exp = '0;
    for (int c = 0; c < 200; c++) begin
      we = !bus.full;
      re = !bus.empty && (bus.dcnt >= 8);
      cycle(we, re, {2 * k + 1, 2 * k});
      if (we) k++;
      if (re) begin
        chk("stream_order", bus.dout, next_exp);
        next_exp++;
      end
      check_model("stream");
    end
    for (int n = 0; n < 2 * DEPTH + 2 && !bus.empty; n++) begin
      cycle(1'b0, 1'b1, 64'd0);
      chk("stream_tail", bus.dout, next_exp);
      next_exp++;
    end
    chk("stream_total", next_exp, 2 * k);
    check_model("stream_end");

    // Random traffic against the queue model.
    for (int c = 0; c < 300; c++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom});
      check_model("rand");
    end

    // Reset mid-traffic.
    for (int c = 0; c < 6; c++) cycle(1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom});
    do_reset("mid");
    check_model("mid_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
